logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_pkg.sv | 24 ++
 rtl/rr_arbiter4.sv | 30 +++
 rtl/logic_unit_arbiter.sv | 115 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter: FSM encoding, opcodes and
// requester count.
package logic_unit_pkg;

   localparam int N_REQ = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   localparam logic [15:0] OP_COUNT_MAX = 16'hFFFF;

   function automatic logic [1:0] ptr_after(input logic [1:0] k);
      return k + 2'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker: first asserted request at or
// after ptr, wrapping modulo 4.
module rr_arbiter4
   import logic_unit_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       ptr,
   output logic [N_REQ-1:0] winner,
   output logic [1:0]       idx
);

   logic       found;
   logic [1:0] cand;

   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ptr + 2'(i);
         if (!found && req[cand]) begin
            found        = 1'b1;
            winner[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of one shared bitwise logic unit; one
// operation in flight, result held until the consumer accepts it.
//
// state   | meaning
// IDLE    | waiting for any request; arbitrates and captures operands
// EXEC    | shared logic unit evaluates captured operands
// RESP    | result presented, waiting for res_ready
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [4*WIDTH-1:0]     op_a,
   input  logic [4*WIDTH-1:0]     op_b,
   input  logic [7:0]             op_sel,
   output logic [N_REQ-1:0]       gnt,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [1:0]             res_id,
   output logic [WIDTH-1:0]       res_data,
   output logic                   busy,
   output logic [15:0]            op_count
);

   state_t             state;
   logic [1:0]         ptr;
   logic [N_REQ-1:0]   win_onehot;
   logic [1:0]         win_idx;
   logic [WIDTH-1:0]   cap_a;
   logic [WIDTH-1:0]   cap_b;
   logic [1:0]         cap_op;
   logic [1:0]         cap_id;
   logic [WIDTH-1:0]   unit_out;

   logic [WIDTH-1:0]   a_slice   [N_REQ];
   logic [WIDTH-1:0]   b_slice   [N_REQ];
   logic [1:0]         sel_slice [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign a_slice[g]   = op_a[g*WIDTH +: WIDTH];
      assign b_slice[g]   = op_b[g*WIDTH +: WIDTH];
      assign sel_slice[g] = op_sel[2*g +: 2];
   end

   rr_arbiter4 u_rr (
      .req    (req),
      .ptr    (ptr),
      .winner (win_onehot),
      .idx    (win_idx)
   );

   // The single logic unit works only on the captured operands.
   always_comb begin
      unit_out = '0;
      case (cap_op)
         OP_AND:  unit_out = cap_a & cap_b;
         OP_OR:   unit_out = cap_a | cap_b;
         OP_XOR:  unit_out = cap_a ^ cap_b;
         OP_NOR:  unit_out = ~(cap_a | cap_b);
         default: unit_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         gnt       <= '0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_op    <= '0;
         cap_id    <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
         busy      <= 1'b0;
         op_count  <= '0;
      end else begin
         gnt <= '0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  cap_a  <= a_slice[win_idx];
                  cap_b  <= b_slice[win_idx];
                  cap_op <= sel_slice[win_idx];
                  cap_id <= win_idx;
                  ptr    <= ptr_after(win_idx);
                  gnt    <= win_onehot;
                  busy   <= 1'b1;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               res_data  <= unit_out;
               res_id    <= cap_id;
               res_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  if (op_count != OP_COUNT_MAX) op_count <= op_count + 16'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed scenarios plus random
// requesters checked against a round-robin reference model.
module tb_logic_unit_arbiter;

   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       req = '0;
   logic [4*W-1:0]   op_a = '0;
   logic [4*W-1:0]   op_b = '0;
   logic [7:0]       op_sel = '0;
   logic             res_ready = 1'b0;
   logic [3:0]       gnt;
   logic             res_valid;
   logic [1:0]       res_id;
   logic [W-1:0]     res_data;
   logic             busy;
   logic [15:0]      op_count;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sel    (op_sel),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy),
      .op_count  (op_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // Reference model and scoreboard
   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   exp_t           exp_q[$];
   int             m_ptr = 0;
   bit             m_idle = 1'b1;
   logic [15:0]    m_cnt = '0;
   logic [3:0]     p_req = '0;
   bit             p_acc = 1'b0;
   bit             p_idle = 1'b1;
   bit             p_gnt = 1'b0;
   logic [4*W-1:0] p_a = '0;
   logic [4*W-1:0] p_b = '0;
   logic [7:0]     p_sel = '0;

   always @(negedge clk) begin : monitor
      int   k;
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         m_ptr  = 0;
         m_idle = 1'b1;
         m_cnt  = '0;
         p_req  = '0;
         p_acc  = 1'b0;
         p_idle = 1'b1;
         p_gnt  = 1'b0;
      end else begin
         if (p_acc) begin
            m_idle = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            check("op_count", 32'(op_count), 32'(m_cnt));
         end
         if (p_idle && p_req != 4'd0) begin
            k = -1;
            for (int i = 0; i < 4; i++)
               if (k < 0 && p_req[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
            check("gnt", 32'(gnt), 32'(1) << k);
            e.id   = 2'(k);
            e.data = ref_op(p_a[k*W +: W], p_b[k*W +: W], p_sel[2*k +: 2]);
            exp_q.push_back(e);
            m_ptr  = (k + 1) % 4;
            m_idle = 1'b0;
         end else if (gnt != 4'd0) begin
            check("spurious_gnt", 32'(gnt), 32'd0);
         end
         if (p_gnt) check("res_valid_latency", 32'(res_valid), 32'd1);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("res_id", 32'(res_id), 32'(e.id));
               check("res_data", 32'(res_data), 32'(e.data));
            end
         end
         p_acc  = res_valid && res_ready;
         p_req  = req;
         p_idle = m_idle;
         p_gnt  = (gnt != 4'd0);
         p_a    = op_a;
         p_b    = op_b;
         p_sel  = op_sel;
      end
   end

   // Stimulus
   bit auto_drop = 1'b1;

   task automatic step();
      @(posedge clk);
      #1;
      if (auto_drop) req = req & ~gnt;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic set_req_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] op);
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
      op_sel[2*i +: 2] = op;
   endtask

   task automatic drain(input int n);
      res_ready = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   int grant_idx[$];
   int grant_cyc[$];

   initial begin : stim
      logic [15:0] cnt0;
      logic [3:0]  exp_seq [5];
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      apply_reset();

      // Single request, OR
      set_req_ops(0, 8'hA5, 8'h0F, 2'b01);
      res_ready = 1'b1;
      req = 4'b0001;
      step();
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_busy", 32'(busy), 32'd1);
      step();
      check("single_gnt_pulse", 32'(gnt), 32'd0);
      check("single_valid", 32'(res_valid), 32'd1);
      check("single_id", 32'(res_id), 32'd0);
      check("single_data", 32'(res_data), 32'hAF);
      step();
      check("single_done", 32'(res_valid), 32'd0);
      drain(2);

      // Contention from a fresh pointer
      apply_reset();
      set_req_ops(0, 8'h3C, 8'hF0, 2'b00);
      set_req_ops(1, 8'h5A, 8'hFF, 2'b10);
      set_req_ops(2, 8'h12, 8'h40, 2'b11);
      set_req_ops(3, 8'h81, 8'h18, 2'b10);
      auto_drop = 1'b0;
      res_ready = 1'b1;
      req = 4'b1111;
      for (int c = 0; c < 16; c++) begin
         step();
         for (int i = 0; i < 4; i++)
            if (gnt[i]) begin
               grant_idx.push_back(i);
               grant_cyc.push_back(c);
            end
      end
      req = '0;
      auto_drop = 1'b1;
      drain(4);
      exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      check("contention_ngrants", 32'(grant_idx.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < grant_idx.size(); i++) begin
         check("contention_order", 32'(grant_idx[i]), 32'(exp_seq[i]));
         if (i > 0) check("contention_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
      end

      // Backpressure while other requests wait
      res_ready = 1'b0;
      set_req_ops(1, 8'hC3, 8'h3C, 2'b11);
      req = 4'b0010;
      step();
      step();
      req = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_gnt", 32'(gnt), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         if (exp_q.size() > 0) check("bp_data", 32'(res_data), 32'(exp_q[0].data));
      end
      cnt0 = m_cnt + 16'd1;
      res_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(res_valid), 32'd0);
      check("bp_release_count", 32'(op_count), 32'(cnt0));
      drain(10);

      // Pointer wrap: grant 3, then 0 must win over 3
      req = 4'b1000;
      step();
      check("wrap_gnt3", 32'(gnt), 32'h8);
      step();
      step();
      req = 4'b1001;
      step();
      check("wrap_gnt0", 32'(gnt), 32'h1);
      drain(8);

      // Random requesters with random backpressure
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               set_req_ops(i, W'($urandom), W'($urandom), 2'($urandom));
               req[i] = 1'b1;
            end
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain(30);
      check("random_drained", 32'(exp_q.size()), 32'd0);

      // Saturation from a preloaded count
      force dut.op_count = 16'hFFFD;
      #1;
      release dut.op_count;
      m_cnt = 16'hFFFD;
      for (int n = 0; n < 4; n++) begin
         set_req_ops(2, W'($urandom), W'($urandom), 2'($urandom));
         req = 4'b0100;
         step();
         step();
         step();
      end
      drain(2);
      check("saturate", 32'(op_count), 32'hFFFF);

      // Reset during EXEC discards the operation
      req = 4'b0001;
      step();
      check("midop_busy", 32'(busy), 32'd1);
      #1;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         check("midop_no_valid", 32'(res_valid), 32'd0);
      end
      check("midop_count", 32'(op_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
